register_file_mp: RTL
=====================

Name: register_file_mp

Overview:
- Parametrised, multi-port successor to the 16x8 shared-bus register file.
- Keeps the shared tristate bus port: combinational read drive, clocked write from the bus.
- Adds two registered auxiliary read ports with write-through bypass, an asynchronous active-high reset with defined contents, and a sequential clear engine.
- Sits between the datapath bus and the ALU operand fetch, so both operands can be read in one cycle.

Parameters:
- DATA_W, 8, data width of each entry and of the bus.
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W entries.
- INIT_INDEX, 1, reset contents: 1 = entry i holds i mod 2**DATA_W; 0 = all entries zero.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- bus  inout  DATA_W  shared data bus; driven only while bus_rd_en=1, else high-Z.
- bus_rd_en  in  1  drive regs[bus_rd_addr] onto the bus (combinational).
- bus_rd_addr  in  ADDR_W  bus read address.
- bus_wr_en  in  1  write bus value into regs[bus_wr_addr] at the clock edge.
- bus_wr_addr  in  ADDR_W  bus write address.
- rd_a_en, rd_b_en  in  1 each  auxiliary read requests.
- rd_a_addr, rd_b_addr  in  ADDR_W each  auxiliary read addresses.
- rd_a_data, rd_b_data  out  DATA_W each  registered auxiliary read data.
- rd_a_valid, rd_b_valid  out  1 each  high for one cycle, the cycle after the request.
- clr_start  in  1  start a sequential clear of all entries.
- clr_busy  out  1  clear engine active.
- wr_drop  out  1  one-cycle pulse: a bus write was discarded because a clear was in progress.

Behaviour:
- Reset (rst=1, asynchronous):
  - Entries take their INIT_INDEX values.
  - rd_a_data, rd_b_data = 0; rd_a_valid, rd_b_valid = 0; clr_busy = 0; wr_drop = 0; FSM = IDLE; clr_ptr = 0.
  - Reset during CLEAR aborts the clear; contents are reinitialised, not left partially cleared.
- Bus read: bus = regs[bus_rd_addr] combinationally while bus_rd_en=1, else all Z. There is no bypass on the bus read.
- Bus write, IDLE state: at the rising edge with bus_wr_en=1, regs[bus_wr_addr] <= bus.
  - bus_rd_en and bus_wr_en in the same cycle performs a register move: regs[wr] <= regs[rd].
- Aux read ports: latency 1 cycle.
  - With rd_x_en=1 at edge N, rd_x_data is valid after edge N and rd_x_valid=1 for that one cycle.
  - With rd_x_en=0, rd_x_valid=0 and rd_x_data holds its previous value.
- Bypass rule for aux reads:
  - A read whose address equals a write committed at the same edge returns the newly written value, not the old one.
  - This applies both to a bus write and to a clear-engine write (returns 0).
- Both aux ports may use the same address; each port is independent.
- Clear FSM, states IDLE and CLEAR:
  - IDLE -> CLEAR on clr_start=1 at the edge; clr_ptr = 0.
    - A bus write in that same cycle still commits; the clear overwrites it later.
  - In CLEAR, each edge sets regs[clr_ptr] <= 0 and increments clr_ptr.
  - After writing entry DEPTH-1: CLEAR -> IDLE and clr_ptr wraps to 0.
  - clr_busy = 1 exactly while in CLEAR, i.e. DEPTH cycles.
  - clr_start while in CLEAR is ignored; there is no restart.
  - A bus write while in CLEAR is discarded; wr_drop = 1 in the following cycle.
  - Bus and aux reads in CLEAR return current contents: already-cleared entries read 0, the rest keep their old values.
- Width rule: INIT_INDEX values truncate to DATA_W bits, e.g. DATA_W=4 with ADDR_W=5 gives entry 17 = 1.

Test Plan:
- Reset with defaults -> aux read of addr 5 gives rd_a_data=0x05 with valid one cycle later; bus read of addr 15 drives 0x0F; bus is Z when bus_rd_en=0.
- Bus write 0xA5 to addr 3 while rd_a_addr=3 and rd_b_addr=4 in the same cycle -> next cycle rd_a_data=0xA5 (bypass) and rd_b_data=0x04.
- Move: bus_rd_addr=7 and bus_wr_addr=2 in the same cycle -> a later read of addr 2 returns 0x07.
- Pulse clr_start -> clr_busy high for exactly 16 cycles. A bus write of 0x55 to addr 9 at cycle 3 of the clear is dropped (wr_drop pulse) and addr 9 reads 0x00 afterwards. Reading addr 12 at clear cycle 5 returns 0x0C.
- Assert rst at clear cycle 8 -> clr_busy drops immediately; all entries read i; the valid outputs are 0.
- DATA_W=16, ADDR_W=3, INIT_INDEX=0 -> all 8 entries read 0x0000; write/read of 0xBEEF at addr 7 round-trips; the clear takes 8 cycles.

Source files
------------

// File: rtl/register_file_mp.sv
// register_file_mp: multi-port register file with a shared tristate bus port, two registered aux read ports and a sequential clear engine
//   clk, rst (async, active high)
//   bus / bus_rd_en / bus_rd_addr / bus_wr_en / bus_wr_addr : shared bus port, combinational read, clocked write
//   rd_{a,b}_en / _addr -> rd_{a,b}_data / _valid           : 1-cycle aux read ports with write-through bypass
//   clr_start -> clr_busy                                    : zeroes one entry per cycle for DEPTH cycles
//   wr_drop                                                  : pulse when a bus write hits an active clear
module register_file_mp #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 4,
    parameter int INIT_INDEX = 1
) (
    input  logic              clk,
    input  logic              rst,
    inout  wire  [DATA_W-1:0] bus,
    input  logic              bus_rd_en,
    input  logic [ADDR_W-1:0] bus_rd_addr,
    input  logic              bus_wr_en,
    input  logic [ADDR_W-1:0] bus_wr_addr,
    input  logic              rd_a_en,
    input  logic [ADDR_W-1:0] rd_a_addr,
    output logic [DATA_W-1:0] rd_a_data,
    output logic              rd_a_valid,
    input  logic              rd_b_en,
    input  logic [ADDR_W-1:0] rd_b_addr,
    output logic [DATA_W-1:0] rd_b_data,
    output logic              rd_b_valid,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic              wr_drop
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state, state_n;
    logic [DATA_W-1:0] regs [DEPTH];
    logic [ADDR_W-1:0] clr_ptr;
    logic [DATA_W-1:0] wr_data, fwd_a, fwd_b;
    logic              wr_commit;

    assign bus = bus_rd_en ? regs[bus_rd_addr] : 'z;

    // A move (read and write together) takes the source entry directly rather than the resolved bus
    assign wr_data   = bus_rd_en ? regs[bus_rd_addr] : bus;
    assign wr_commit = bus_wr_en && state == IDLE;
    assign clr_busy  = state == CLEAR;

    // Aux reads see whatever is committed at the same edge: clear zero first, then bus write
    assign fwd_a = (clr_busy && rd_a_addr == clr_ptr) ? '0 :
                   (wr_commit && rd_a_addr == bus_wr_addr) ? wr_data : regs[rd_a_addr];
    assign fwd_b = (clr_busy && rd_b_addr == clr_ptr) ? '0 :
                   (wr_commit && rd_b_addr == bus_wr_addr) ? wr_data : regs[rd_b_addr];

    always_comb begin
        state_n = state;
        if (state == IDLE)
            state_n = clr_start ? CLEAR : IDLE;
        else
            state_n = (&clr_ptr) ? IDLE : CLEAR;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                regs[i] <= (INIT_INDEX != 0) ? DATA_W'(i) : '0;
        end else if (state == CLEAR) begin
            regs[clr_ptr] <= '0;
        end else if (bus_wr_en) begin
            regs[bus_wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            clr_ptr    <= '0;
            wr_drop    <= 1'b0;
            rd_a_valid <= 1'b0;
            rd_b_valid <= 1'b0;
            rd_a_data  <= '0;
            rd_b_data  <= '0;
        end else begin
            state      <= state_n;
            clr_ptr    <= (state == CLEAR) ? clr_ptr + 1'b1 : '0;
            wr_drop    <= bus_wr_en && state == CLEAR;
            rd_a_valid <= rd_a_en;
            rd_b_valid <= rd_b_en;
            if (rd_a_en)
                rd_a_data <= fwd_a;
            if (rd_b_en)
                rd_b_data <= fwd_b;
        end
    end
endmodule
